// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared FSM encoding, region indices and default error word for the memory bus bridge
package mem_bus_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;
  localparam logic REGION_SRAM = 1'b0;
  localparam logic REGION_IO   = 1'b1;
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;
endpackage

// File: rtl/bus_addr_decode.sv
// bus_addr_decode: combinational region hit detection against the aligned SRAM and IO windows
module bus_addr_decode
  import mem_bus_pkg::*;
#(
  parameter logic [31:0] SRAM_BASE      = 32'h0000_0000,
  parameter int          SRAM_SIZE_LOG2 = 13,
  parameter logic [31:0] IO_BASE        = 32'h8000_0000,
  parameter int          IO_SIZE_LOG2   = 16
) (
  input  logic [31:0] mem_addr,
  output logic        hit_sram,
  output logic        hit_io
);
  assign hit_sram = mem_addr[31:SRAM_SIZE_LOG2] == SRAM_BASE[31:SRAM_SIZE_LOG2];
  assign hit_io   = mem_addr[31:IO_SIZE_LOG2] == IO_BASE[31:IO_SIZE_LOG2];
endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: bridges the picorv32 native memory interface to the SRAM and IO slaves with timeout and error reporting
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter logic [31:0] SRAM_BASE      = 32'h0000_0000,
  parameter int          SRAM_SIZE_LOG2 = 13,
  parameter logic [31:0] IO_BASE        = 32'h8000_0000,
  parameter int          IO_SIZE_LOG2   = 16,
  parameter int          TIMEOUT        = 255,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  output logic        sram_select,
  input  logic        sram_ready,
  input  logic [31:0] sram_rdata,
  output logic        io_select,
  input  logic        io_ready,
  input  logic [31:0] io_rdata,
  output logic        err_pulse,
  output logic [31:0] err_addr
);
  localparam logic [15:0] TO = 16'(TIMEOUT);
  logic [1:0]  state;
  logic        region;
  logic [15:0] cnt;
  logic        hit_sram, hit_io;
  logic        sel_ready;
  logic [31:0] sel_rdata;

  bus_addr_decode #(
    .SRAM_BASE(SRAM_BASE), .SRAM_SIZE_LOG2(SRAM_SIZE_LOG2),
    .IO_BASE(IO_BASE), .IO_SIZE_LOG2(IO_SIZE_LOG2)
  ) u_dec (
    .mem_addr(mem_addr),
    .hit_sram(hit_sram),
    .hit_io(hit_io)
  );

  // only the slave owning the current transaction is listened to
  always_comb begin
    sel_ready = region == REGION_IO ? io_ready : sram_ready;
    sel_rdata = region == REGION_IO ? io_rdata : sram_rdata;
  end

  // transaction FSM; every output is a register so the CPU never sees a combinational path
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      region      <= REGION_SRAM;
      cnt         <= '0;
      mem_ready   <= 1'b0;
      mem_rdata   <= '0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      bus_wstrb   <= '0;
      sram_select <= 1'b0;
      io_select   <= 1'b0;
      err_pulse   <= 1'b0;
      err_addr    <= '0;
    end else begin
      sram_select <= 1'b0;
      io_select   <= 1'b0;
      mem_ready   <= 1'b0;
      err_pulse   <= 1'b0;
      case (state)
        ST_IDLE: if (mem_valid) begin
          bus_addr  <= mem_addr;
          bus_wdata <= mem_wdata;
          bus_wstrb <= mem_wstrb;
          if (hit_sram || hit_io) begin
            region      <= hit_sram ? REGION_SRAM : REGION_IO;
            sram_select <= hit_sram;
            io_select   <= !hit_sram;
            state       <= ST_REQ;
          end else begin
            mem_ready <= 1'b1;
            mem_rdata <= ERR_DATA;
            err_pulse <= 1'b1;
            err_addr  <= mem_addr;
            state     <= ST_RESP;
          end
        end
        ST_REQ: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: if (sel_ready) begin
          mem_ready <= 1'b1;
          mem_rdata <= sel_rdata;
          state     <= ST_RESP;
        end else if (cnt + 16'd1 == TO) begin
          mem_ready <= 1'b1;
          mem_rdata <= ERR_DATA;
          err_pulse <= 1'b1;
          err_addr  <= bus_addr;
          state     <= ST_RESP;
        end else begin
          cnt <= cnt + 16'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: directed self-checking bench for the memory bus bridge
module tb_mem_bus_ctrl;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        sram_select;
  logic        sram_ready;
  logic [31:0] sram_rdata;
  logic        io_select;
  logic        io_ready;
  logic [31:0] io_rdata;
  logic        err_pulse;
  logic [31:0] err_addr;

  logic        sram_rdy_q;
  logic        sram_kick = 1'b0;
  logic [31:0] sram_mem [0:15];
  int          io_lat = 1;
  int          io_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  int          r_cyc, s_cyc, i_cyc, s_n, i_n, e_n;
  logic [31:0] r_data, e_addr, b_addr, b_wdata;
  logic [3:0]  b_wstrb;

  always #5 clk = ~clk;

  mem_bus_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .sram_select(sram_select), .sram_ready(sram_ready), .sram_rdata(sram_rdata),
    .io_select(io_select), .io_ready(io_ready), .io_rdata(io_rdata),
    .err_pulse(err_pulse), .err_addr(err_addr)
  );

  assign sram_ready = sram_rdy_q | sram_kick;
  assign io_rdata   = 32'h0000_00A5;

  // SRAM model: answers one cycle after select, byte-strobed write, returns the old word
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sram_rdy_q <= 1'b0;
      sram_rdata <= '0;
      for (int k = 0; k < 16; k++) sram_mem[k] <= '0;
      sram_mem[4] <= 32'h1234_5678;
    end else begin
      sram_rdy_q <= 1'b0;
      if (sram_select) begin
        sram_rdy_q <= 1'b1;
        sram_rdata <= sram_mem[bus_addr[5:2]];
        for (int b = 0; b < 4; b++)
          if (bus_wstrb[b]) sram_mem[bus_addr[5:2]][8*b +: 8] <= bus_wdata[8*b +: 8];
      end
    end
  end

  // IO model: ready io_lat cycles after select; io_lat=0 never answers
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      io_ready <= 1'b0;
      io_cnt   <= 0;
    end else begin
      io_ready <= 1'b0;
      if (io_select && io_lat == 1) io_ready <= 1'b1;
      else if (io_select && io_lat > 1) io_cnt <= io_lat - 1;
      else if (io_cnt > 0) begin
        io_cnt <= io_cnt - 1;
        if (io_cnt == 1) io_ready <= 1'b1;
      end
    end
  end

  // called at a falling edge: that cycle is cycle 0; returns at the falling edge of the mem_ready cycle
  task automatic xact(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
    mem_addr = a; mem_wdata = w; mem_wstrb = s; mem_valid = 1'b1;
    r_cyc = -1; s_cyc = -1; i_cyc = -1; s_n = 0; i_n = 0; e_n = 0;
    for (int c = 1; c <= 20 && r_cyc < 0; c++) begin
      @(negedge clk);
      if (sram_select) begin s_n++; s_cyc = c; end
      if (io_select) begin i_n++; i_cyc = c; end
      if (err_pulse) e_n++;
      if (mem_ready) begin
        r_cyc = c; r_data = mem_rdata; e_addr = err_addr;
        b_addr = bus_addr; b_wdata = bus_wdata; b_wstrb = bus_wstrb;
        mem_valid = 1'b0;
      end
    end
    mem_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (mem_ready !== 1'b0) begin n_bad++; $display("FAIL reset mem_ready got %b want 0", mem_ready); end
    n_cmp++; if (mem_rdata !== 32'h0) begin n_bad++; $display("FAIL reset mem_rdata got %h want 0", mem_rdata); end
    n_cmp++; if ({sram_select, io_select, err_pulse} !== 3'b000) begin n_bad++; $display("FAIL reset selects/err got %b want 000", {sram_select, io_select, err_pulse}); end
    n_cmp++; if ({bus_addr, bus_wdata, bus_wstrb, err_addr} !== 100'h0) begin n_bad++; $display("FAIL reset bus/err_addr got %h want 0", {bus_addr, bus_wdata, bus_wstrb, err_addr}); end
    reset_n = 1'b1;
  endtask

  task automatic test_sram_read();
    @(negedge clk);
    xact(32'h0000_0010, 32'h0, 4'h0);
    n_cmp++; if (s_cyc !== 1 || s_n !== 1) begin n_bad++; $display("FAIL sram_rd select cycle/count got %0d/%0d want 1/1", s_cyc, s_n); end
    n_cmp++; if (b_addr !== 32'h10) begin n_bad++; $display("FAIL sram_rd bus_addr got %h want 00000010", b_addr); end
    n_cmp++; if (r_cyc !== 3) begin n_bad++; $display("FAIL sram_rd ready cycle got %0d want 3", r_cyc); end
    n_cmp++; if (r_data !== 32'h1234_5678) begin n_bad++; $display("FAIL sram_rd rdata got %h want 12345678", r_data); end
    n_cmp++; if (e_n !== 0 || i_n !== 0) begin n_bad++; $display("FAIL sram_rd err/io count got %0d/%0d want 0/0", e_n, i_n); end
    @(negedge clk);
    n_cmp++; if (mem_ready !== 1'b0) begin n_bad++; $display("FAIL sram_rd ready pulse width got %b want 0", mem_ready); end
    n_cmp++; if (mem_rdata !== 32'h1234_5678) begin n_bad++; $display("FAIL sram_rd rdata hold got %h want 12345678", mem_rdata); end
  endtask

  task automatic test_io_write();
    io_lat = 1;
    @(negedge clk);
    xact(32'h8000_0004, 32'h0000_AB00, 4'b0010);
    n_cmp++; if (i_cyc !== 1 || i_n !== 1) begin n_bad++; $display("FAIL io_wr select cycle/count got %0d/%0d want 1/1", i_cyc, i_n); end
    n_cmp++; if (s_n !== 0) begin n_bad++; $display("FAIL io_wr sram_select count got %0d want 0", s_n); end
    n_cmp++; if (b_wstrb !== 4'b0010 || b_wdata !== 32'h0000_AB00) begin n_bad++; $display("FAIL io_wr bus strb/wdata got %b/%h want 0010/0000ab00", b_wstrb, b_wdata); end
    n_cmp++; if (b_addr !== 32'h8000_0004) begin n_bad++; $display("FAIL io_wr bus_addr got %h want 80000004", b_addr); end
    n_cmp++; if (r_cyc !== 3 || e_n !== 0) begin n_bad++; $display("FAIL io_wr ready cycle/err got %0d/%0d want 3/0", r_cyc, e_n); end
    n_cmp++; if (r_data !== 32'h0000_00A5) begin n_bad++; $display("FAIL io_wr rdata got %h want 000000a5", r_data); end
  endtask

  task automatic test_unmapped();
    @(negedge clk);
    xact(32'h4000_0000, 32'h0, 4'h0);
    n_cmp++; if (s_n !== 0 || i_n !== 0) begin n_bad++; $display("FAIL unmapped selects got %0d/%0d want 0/0", s_n, i_n); end
    n_cmp++; if (r_cyc !== 1) begin n_bad++; $display("FAIL unmapped ready cycle got %0d want 1", r_cyc); end
    n_cmp++; if (r_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL unmapped rdata got %h want deadbeef", r_data); end
    n_cmp++; if (e_n !== 1 || e_addr !== 32'h4000_0000) begin n_bad++; $display("FAIL unmapped err count/addr got %0d/%h want 1/40000000", e_n, e_addr); end
  endtask

  task automatic test_timeout();
    io_lat = 0;
    @(negedge clk);
    xact(32'h8000_0008, 32'h0, 4'h0);
    n_cmp++; if (i_cyc !== 1) begin n_bad++; $display("FAIL timeout select cycle got %0d want 1", i_cyc); end
    n_cmp++; if (r_cyc !== 6) begin n_bad++; $display("FAIL timeout ready cycle got %0d want 6", r_cyc); end
    n_cmp++; if (r_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL timeout rdata got %h want deadbeef", r_data); end
    n_cmp++; if (e_n !== 1 || e_addr !== 32'h8000_0008) begin n_bad++; $display("FAIL timeout err count/addr got %0d/%h want 1/80000008", e_n, e_addr); end
    io_lat = 4;
    @(negedge clk);
    xact(32'h8000_000C, 32'h0, 4'h0);
    n_cmp++; if (r_cyc !== 6) begin n_bad++; $display("FAIL late_ready ready cycle got %0d want 6", r_cyc); end
    n_cmp++; if (r_data !== 32'h0000_00A5 || e_n !== 0) begin n_bad++; $display("FAIL late_ready rdata/err got %h/%0d want 000000a5/0", r_data, e_n); end
    n_cmp++; if (e_addr !== 32'h8000_0008) begin n_bad++; $display("FAIL late_ready err_addr hold got %h want 80000008", e_addr); end
    io_lat = 1;
  endtask

  task automatic test_back_to_back();
    int sel_tot, rdy_tot;
    @(negedge clk);
    xact(32'h0000_0010, 32'h0, 4'h0);
    sel_tot = s_n; rdy_tot = (r_cyc > 0) ? 1 : 0;
    n_cmp++; if (r_data !== 32'h1234_5678) begin n_bad++; $display("FAIL b2b first rdata got %h want 12345678", r_data); end
    @(negedge clk);
    xact(32'h0000_0004, 32'hCAFE_F00D, 4'hF);
    sel_tot += s_n; rdy_tot += (r_cyc > 0) ? 1 : 0;
    n_cmp++; if (r_cyc !== 3 || s_cyc !== 1) begin n_bad++; $display("FAIL b2b second ready/select cycle got %0d/%0d want 3/1", r_cyc, s_cyc); end
    n_cmp++; if (sel_tot !== 2 || rdy_tot !== 2) begin n_bad++; $display("FAIL b2b select/ready totals got %0d/%0d want 2/2", sel_tot, rdy_tot); end
    n_cmp++; if (sram_mem[1] !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL b2b sram word1 got %h want cafef00d", sram_mem[1]); end
    @(negedge clk);
    xact(32'h0000_0004, 32'h0, 4'h0);
    n_cmp++; if (r_data !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL b2b readback got %h want cafef00d", r_data); end
  endtask

  task automatic test_reset_wait();
    int seen;
    @(negedge clk);
    mem_addr = 32'h0000_0010; mem_wdata = 32'h0; mem_wstrb = 4'h0; mem_valid = 1'b1;
    @(negedge clk);
    n_cmp++; if (sram_select !== 1'b1) begin n_bad++; $display("FAIL rst_wait select before reset got %b want 1", sram_select); end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_cmp++; if ({mem_ready, sram_select, io_select, err_pulse} !== 4'b0000) begin n_bad++; $display("FAIL rst_wait control outputs got %b want 0000", {mem_ready, sram_select, io_select, err_pulse}); end
    n_cmp++; if ({mem_rdata, bus_addr, bus_wdata, bus_wstrb, err_addr} !== 132'h0) begin n_bad++; $display("FAIL rst_wait data outputs got %h want 0", {mem_rdata, bus_addr, bus_wdata, bus_wstrb, err_addr}); end
    mem_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    sram_kick = 1'b1;
    seen = 0;
    @(negedge clk);
    sram_kick = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (mem_ready) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rst_wait stray mem_ready count got %0d want 0", seen); end
    xact(32'h0000_0010, 32'h0, 4'h0);
    n_cmp++; if (r_cyc !== 3 || r_data !== 32'h1234_5678) begin n_bad++; $display("FAIL rst_wait post-reset read got %0d/%h want 3/12345678", r_cyc, r_data); end
  endtask

  initial begin
    test_reset();
    test_sram_read();
    test_io_write();
    test_unmapped();
    test_timeout();
    test_back_to_back();
    test_reset_wait();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
